regfile_wb_arbiter: RTL

//  Shares the single register-file write port between ALU writeback and LDR

---
 rtl/regfile_wb_arbiter_if.sv | 36 +++
 rtl/regfile_wb_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request / register-file write port bundle for regfile_wb_arbiter.
// The master is the pipeline side; the slave is the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned DEPTH  = 4
) ();
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              alu_w_en;
    logic [REG_AW-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              ldr_w_en;
    logic [REG_AW-1:0] ldr_rt;
    logic [DATA_W-1:0] ldr_data;
    logic [REG_AW-1:0] rd_addr_a;
    logic [REG_AW-1:0] rd_addr_b;
    logic              rf_w_en;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              stall;
    logic              hazard_a;
    logic              hazard_b;
    logic [CW-1:0]     pend_count;
    logic              overflow_err;

    modport master (
        output alu_w_en, alu_rd, alu_data, ldr_w_en, ldr_rt, ldr_data, rd_addr_a, rd_addr_b,
        input  rf_w_en, rf_waddr, rf_wdata, stall, hazard_a, hazard_b, pend_count, overflow_err
    );

    modport slave (
        input  alu_w_en, alu_rd, alu_data, ldr_w_en, ldr_rt, ldr_data, rd_addr_a, rd_addr_b,
        output rf_w_en, rf_waddr, rf_wdata, stall, hazard_a, hazard_b, pend_count, overflow_err
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and LDR writebacks onto one register-file write port, in age order,
// buffering losers in an in-order pending FIFO and flagging RAW hazards on pending writes.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned DEPTH  = 4
) (
    input logic                clk,
    input logic                rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] StallLevel = CW'(DEPTH - 1);

    logic [REG_AW-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;

    logic              stall;
    logic              ldr_req, alu_req;
    logic              head_valid;
    logic              pop;
    logic              push0, push1;
    logic [REG_AW-1:0] push0_addr, push1_addr;
    logic [DATA_W-1:0] push0_data, push1_data;
    logic              hz_a, hz_b;
    logic [PW-1:0]     offset;

    always_comb begin
        stall        = !rst && (count_q >= StallLevel);
        ldr_req      = bus.ldr_w_en && !stall;
        alu_req      = bus.alu_w_en && !stall;
        head_valid   = (count_q != '0);
        pop          = head_valid;
        push0        = 1'b0;
        push1        = 1'b0;
        push0_addr   = bus.ldr_rt;
        push0_data   = bus.ldr_data;
        push1_addr   = bus.alu_rd;
        push1_data   = bus.alu_data;
        bus.rf_w_en  = 1'b0;
        bus.rf_waddr = '0;
        bus.rf_wdata = '0;

        // Age order: FIFO head, then same-cycle LDR, then same-cycle ALU.
        if (head_valid) begin
            bus.rf_w_en  = 1'b1;
            bus.rf_waddr = addr_q[rd_ptr_q];
            bus.rf_wdata = data_q[rd_ptr_q];
            if (ldr_req) begin
                push0 = 1'b1;
                push1 = alu_req;
            end else if (alu_req) begin
                push0      = 1'b1;
                push0_addr = bus.alu_rd;
                push0_data = bus.alu_data;
            end
        end else if (ldr_req) begin
            bus.rf_w_en  = 1'b1;
            bus.rf_waddr = bus.ldr_rt;
            bus.rf_wdata = bus.ldr_data;
            if (alu_req) begin
                push0      = 1'b1;
                push0_addr = bus.alu_rd;
                push0_data = bus.alu_data;
            end
        end else if (alu_req) begin
            bus.rf_w_en  = 1'b1;
            bus.rf_waddr = bus.alu_rd;
            bus.rf_wdata = bus.alu_data;
        end

        if (rst) begin
            bus.rf_w_en = 1'b0;
        end

        count_d    = count_q + CW'(push0) + CW'(push1) - CW'(pop);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push0) + PW'(push1);
        overflow_d = overflow_q | (stall & (bus.ldr_w_en | bus.alu_w_en));
    end

    // An entry is valid when its distance from the head is below the occupancy.
    always_comb begin
        hz_a   = 1'b0;
        hz_b   = 1'b0;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - rd_ptr_q;
            if ({1'b0, offset} < count_q) begin
                if (addr_q[i] == bus.rd_addr_a) hz_a = 1'b1;
                if (addr_q[i] == bus.rd_addr_b) hz_b = 1'b1;
            end
        end
        if (rst) begin
            hz_a = 1'b0;
            hz_b = 1'b0;
        end
    end

    assign bus.stall        = stall;
    assign bus.hazard_a     = hz_a;
    assign bus.hazard_b     = hz_b;
    assign bus.pend_count   = count_q;
    assign bus.overflow_err = overflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push0) begin
                addr_q[wr_ptr_q] <= push0_addr;
                data_q[wr_ptr_q] <= push0_data;
            end
            if (push1) begin
                addr_q[wr_ptr_q + PW'(1)] <= push1_addr;
                data_q[wr_ptr_q + PW'(1)] <= push1_data;
            end
        end
    end
endmodule
